// File: rtl/compare_sweep_checker.sv
// compare_sweep_checker: synthesizable BIST that sweeps every operand pair
// through an N-bit magnitude comparator. It holds each pair for HOLD_CYCLES
// extra settle cycles and then samples the eq/lt/gt flags. Each sample is
// checked against a local reference. The block counts failing vectors and
// remembers the first one that failed.
module compare_sweep_checker #(
    parameter int WIDTH       = 2,
    parameter int HOLD_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic [WIDTH-1:0]     a_out,
    output logic [WIDTH-1:0]     b_out,
    input  logic                 eq_in,
    input  logic                 lt_in,
    input  logic                 gt_in,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [2*WIDTH:0]     err_count,
    output logic [WIDTH-1:0]     first_err_a,
    output logic [WIDTH-1:0]     first_err_b
);

    localparam int VEC_W = 2 * WIDTH;
    localparam int ERR_W = 2 * WIDTH + 1;
    localparam int CNT_W = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    // {a, b} concatenated, so that b wraps into a when the pair is incremented.
    logic [VEC_W-1:0]   vec_q, vec_d;
    logic [ERR_W-1:0]   err_q, err_d;
    logic [WIDTH-1:0]   first_a_q, first_a_d;
    logic [WIDTH-1:0]   first_b_q, first_b_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               pass_q, pass_d;

    logic [WIDTH-1:0]   cur_a, cur_b;
    logic [2:0]         exp_flags;
    logic               vec_fail;

    assign cur_a = vec_q[VEC_W-1:WIDTH];
    assign cur_b = vec_q[WIDTH-1:0];

    // Reference flags for the pair currently driven.
    always_comb begin
        exp_flags = {cur_a == cur_b, cur_a < cur_b, cur_a > cur_b};
        vec_fail  = ({eq_in, lt_in, gt_in} != exp_flags);
    end

    // Sequencer: next state, operand stepping and result bookkeeping.
    always_comb begin
        // NOTE: every _d is defaulted to its _q first so that no path leaves a
        // variable unassigned, which would infer a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        vec_d     = vec_q;
        err_d     = err_q;
        first_a_d = first_a_q;
        first_b_d = first_b_q;
        busy_d    = busy_q;
        done_d    = done_q;
        pass_d    = pass_q;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d   = S_RUN;
                    vec_d     = '0;
                    cnt_d     = CNT_W'(HOLD_CYCLES);
                    err_d     = '0;
                    first_a_d = '0;
                    first_b_d = '0;
                    busy_d    = 1'b1;
                    done_d    = 1'b0;
                    pass_d    = 1'b0;
                end
            end
            S_RUN: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    if (vec_fail) begin
                        err_d = err_q + 1'b1;
                        // A zero count before this increment means this is the first failure.
                        if (err_q == '0) begin
                            first_a_d = cur_a;
                            first_b_d = cur_b;
                        end
                    end
                    if (&vec_q) begin
                        state_d = S_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = (err_d == '0);
                    end else begin
                        vec_d = vec_q + 1'b1;
                        cnt_d = CNT_W'(HOLD_CYCLES);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers, cleared asynchronously by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            vec_q     <= '0;
            err_q     <= '0;
            first_a_q <= '0;
            first_b_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here, so every register updates from
            // the same pre-edge values regardless of statement order.
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            vec_q     <= vec_d;
            err_q     <= err_d;
            first_a_q <= first_a_d;
            first_b_q <= first_b_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
        end
    end

    assign a_out       = cur_a;
    assign b_out       = cur_b;
    assign busy        = busy_q;
    assign done        = done_q;
    assign pass        = pass_q;
    assign err_count   = err_q;
    assign first_err_a = first_a_q;
    assign first_err_b = first_b_q;

endmodule

// File: tb/tb_compare_sweep_checker.sv
// Bench for compare_sweep_checker. It uses two instances: one with the default
// hold time and one with HOLD_CYCLES=0. Each instance is fed by a behavioural
// comparator with selectable faults. Every sweep's expected outcome comes from
// enumerating all pairs in order.
module tb_compare_sweep_checker;

    localparam int W = 2;

    logic       clk = 1'b0;
    logic       rst_n_w [2];
    logic       start_w [2];
    logic [W-1:0] a_w [2];
    logic [W-1:0] b_w [2];
    logic       eq_w [2];
    logic       lt_w [2];
    logic       gt_w [2];
    logic       busy_w [2];
    logic       done_w [2];
    logic       pass_w [2];
    logic [2*W:0] err_w [2];
    logic [W-1:0] fa_w [2];
    logic [W-1:0] fb_w [2];

    // Comparator fault mode per instance:
    // 0 correct, 1 eq stuck 0, 2 lt/gt swapped, 3 all ones, 4 random xor mask.
    int         mode [2];
    logic [2:0] corrupt [2][16];

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    compare_sweep_checker #(.WIDTH(W), .HOLD_CYCLES(1)) dut (
        .clk(clk), .rst_n(rst_n_w[0]), .start(start_w[0]),
        .a_out(a_w[0]), .b_out(b_w[0]),
        .eq_in(eq_w[0]), .lt_in(lt_w[0]), .gt_in(gt_w[0]),
        .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]),
        .err_count(err_w[0]), .first_err_a(fa_w[0]), .first_err_b(fb_w[0])
    );

    compare_sweep_checker #(.WIDTH(W), .HOLD_CYCLES(0)) dut_h0 (
        .clk(clk), .rst_n(rst_n_w[1]), .start(start_w[1]),
        .a_out(a_w[1]), .b_out(b_w[1]),
        .eq_in(eq_w[1]), .lt_in(lt_w[1]), .gt_in(gt_w[1]),
        .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]),
        .err_count(err_w[1]), .first_err_a(fa_w[1]), .first_err_b(fb_w[1])
    );

    // Behavioural comparator, possibly faulty, returning {eq, lt, gt}.
    function automatic logic [2:0] cmp_flags(input int m, input logic [2:0] mask,
                                             input int a, input int b);
        logic [2:0] good;
        good = {a == b, a < b, a > b};
        case (m)
            1:       return {1'b0, good[1], good[0]};
            2:       return {good[2], good[0], good[1]};
            3:       return 3'b111;
            4:       return good ^ mask;
            default: return good;
        endcase
    endfunction

    always_comb begin
        {eq_w[0], lt_w[0], gt_w[0]} = cmp_flags(mode[0], corrupt[0][{a_w[0], b_w[0]}],
                                                int'(a_w[0]), int'(b_w[0]));
        {eq_w[1], lt_w[1], gt_w[1]} = cmp_flags(mode[1], corrupt[1][{a_w[1], b_w[1]}],
                                                int'(a_w[1]), int'(b_w[1]));
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, want);
        end
    endtask

    // Run one full sweep on instance k with comparator mode m and check the results.
    task automatic run_sweep(input int k, input int m, input bit pulse_mid);
        int hold;
        int cyc;
        int order_bad;
        int exp_err;
        int exp_fa;
        int exp_fb;
        bit found;
        logic [2:0] got_flags;
        logic [2:0] ideal;

        hold = (k == 0) ? 1 : 0;
        @(negedge clk);
        mode[k] = m;
        for (int i = 0; i < 16; i++) begin
            if (m == 4 && $urandom_range(0, 2) == 0) corrupt[k][i] = 3'($urandom_range(1, 7));
            else corrupt[k][i] = 3'b000;
        end

        // Reference: walk all pairs in sweep order, a outer and b inner.
        exp_err = 0; exp_fa = 0; exp_fb = 0; found = 1'b0;
        for (int a = 0; a < 4; a++) begin
            for (int b = 0; b < 4; b++) begin
                got_flags = cmp_flags(m, corrupt[k][a*4+b], a, b);
                ideal = 3'b000;
                if (a == b) ideal = 3'b100;
                else if (a < b) ideal = 3'b010;
                else ideal = 3'b001;
                if (got_flags != ideal) begin
                    exp_err++;
                    if (!found) begin
                        found = 1'b1; exp_fa = a; exp_fb = b;
                    end
                end
            end
        end

        start_w[k] = 1'b1;
        @(negedge clk);
        start_w[k] = 1'b0;
        check("busy_after_start", 32'(busy_w[k]), 1);
        check("done_cleared", 32'(done_w[k]), 0);
        check("err_cleared", 32'(err_w[k]), 0);
        check("pass_cleared", 32'(pass_w[k]), 0);

        cyc = 0;
        order_bad = 0;
        while (cyc < 200 && !done_w[k]) begin
            if ({a_w[k], b_w[k]} != 4'(cyc / (hold + 1))) order_bad++;
            start_w[k] = pulse_mid && (cyc == 9);
            @(negedge clk);
            cyc++;
        end
        start_w[k] = 1'b0;

        check("sweep_cycles", 32'(cyc), 32'(16 * (hold + 1)));
        check("vector_order", 32'(order_bad), 0);
        check("err_count", 32'(err_w[k]), 32'(exp_err));
        check("first_err_a", 32'(fa_w[k]), 32'(exp_fa));
        check("first_err_b", 32'(fb_w[k]), 32'(exp_fb));
        check("pass", 32'(pass_w[k]), 32'(exp_err == 0));
        check("busy_at_done", 32'(busy_w[k]), 0);

        // Results must hold in DONE while start stays low.
        repeat (3) @(negedge clk);
        check("done_held", 32'(done_w[k]), 1);
        check("err_held", 32'(err_w[k]), 32'(exp_err));
        check("last_vec_held", 32'({a_w[k], b_w[k]}), 32'hF);
    endtask

    initial begin
        int wait_cyc;

        mode[0] = 0; mode[1] = 0;
        for (int i = 0; i < 16; i++) begin
            corrupt[0][i] = 3'b000;
            corrupt[1][i] = 3'b000;
        end
        rst_n_w[0] = 1'b0; rst_n_w[1] = 1'b0;
        start_w[0] = 1'b0; start_w[1] = 1'b0;
        #23;
        check("rst_busy", 32'(busy_w[0]), 0);
        check("rst_done", 32'(done_w[0]), 0);
        check("rst_pass", 32'(pass_w[0]), 0);
        check("rst_err", 32'(err_w[0]), 0);
        check("rst_ab", 32'({a_w[0], b_w[0]}), 0);
        check("rst_first", 32'({fa_w[0], fb_w[0]}), 0);
        @(negedge clk);
        rst_n_w[0] = 1'b1; rst_n_w[1] = 1'b1;
        @(negedge clk);
        check("idle_no_start", 32'(busy_w[0]), 0);

        run_sweep(0, 0, 1'b0);
        run_sweep(0, 1, 1'b0);
        run_sweep(0, 2, 1'b0);
        run_sweep(0, 3, 1'b0);
        // Restart from DONE with a stray start mid-run; pass must recompute.
        run_sweep(0, 0, 1'b1);
        for (int r = 0; r < 4; r++) run_sweep(0, 4, r == 1);

        // Reset mid-sweep when the (1,1) vector is on the bus.
        @(negedge clk);
        mode[0] = 0;
        start_w[0] = 1'b1;
        @(negedge clk);
        start_w[0] = 1'b0;
        wait_cyc = 0;
        while (wait_cyc < 100 && {a_w[0], b_w[0]} != 4'b0101) begin
            @(negedge clk);
            wait_cyc++;
        end
        check("reach_1_1", 32'({a_w[0], b_w[0]}), 32'h5);
        #2 rst_n_w[0] = 1'b0;
        #1;
        check("async_rst_busy", 32'(busy_w[0]), 0);
        check("async_rst_ab", 32'({a_w[0], b_w[0]}), 0);
        check("async_rst_err", 32'(err_w[0]), 0);
        check("async_rst_done", 32'(done_w[0]), 0);
        @(negedge clk);
        rst_n_w[0] = 1'b1;
        repeat (4) @(negedge clk);
        check("no_resume_busy", 32'(busy_w[0]), 0);
        check("no_resume_ab", 32'({a_w[0], b_w[0]}), 0);

        // Zero-hold instance: 16-cycle sweeps.
        run_sweep(1, 0, 1'b0);
        run_sweep(1, 2, 1'b0);
        run_sweep(1, 4, 1'b0);
        run_sweep(0, 4, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
